// File: rtl/demux_1x2_buf.sv
// demux_1x2_buf
//   Steers one producer stream into two independently stalling consumers.
//   Each word goes to channel A (in_sel=0) or channel B (in_sel=1), where it
//   is queued in a small per-channel FIFO with a valid/ready output side.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready reflects the channel
//                       currently chosen by in_sel, independent of in_valid
//   in_sel, in_data     channel select and input word
//   a_valid/a_ready     channel A consumer handshake, a_data is the head word
//   a_level             channel A occupancy (0..DEPTH)
//   b_*                 same as a_* for channel B
//
// The file also holds demux_1x2_buf_fifo, the per-channel queue.

module demux_1x2_buf_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH) + 1,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,   // already qualified against full
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_req_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  // A pop request on an empty queue is dropped so the level never underflows.
  assign pop     = pop_req_i && valid_o;
  // Forced to zero when empty so stale storage never leaks to the consumer.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(push_i) - LW'(pop);
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; the level gate on data_o hides its contents.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

module demux_1x2_buf #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [LW-1:0]    a_level,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [LW-1:0]    b_level
);

  logic a_full, b_full;
  logic push_a, push_b;

  // Ready uses the pre-edge level, so a full queue refuses a push even if
  // it is popping in the same cycle.
  assign in_ready = in_sel ? !b_full : !a_full;
  assign push_a   = in_valid && in_ready && !in_sel;
  assign push_b   = in_valid && in_ready &&  in_sel;

  demux_1x2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_a),
    .wdata_i   (in_data),
    .pop_req_i (a_ready),
    .valid_o   (a_valid),
    .data_o    (a_data),
    .level_o   (a_level),
    .full_o    (a_full)
  );

  demux_1x2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_b),
    .wdata_i   (in_data),
    .pop_req_i (b_ready),
    .valid_o   (b_valid),
    .data_o    (b_data),
    .level_o   (b_level),
    .full_o    (b_full)
  );

endmodule

// File: tb/tb_demux_1x2_buf.sv
module tb_demux_1x2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [15:0] in_data;
  logic        a_valid, a_ready;
  logic [15:0] a_data;
  logic [1:0]  a_level;
  logic        b_valid, b_ready;
  logic [15:0] b_data;
  logic [1:0]  b_level;

  int passed = 0;
  int total  = 0;

  demux_1x2_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_level  (a_level),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_level  (b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge, leaving 1 time unit for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    a_ready = 1'b0;
    b_ready = 1'b0;

    // Power-on reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_b_level", b_level, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    #10 rst = 1'b0;   // released between edges
    tick();

    // Asynchronous reset between edges with in_valid high
    drive(1'b1, 1'b0, 16'h5555);
    tick();
    chk("pre_arst_a_valid", a_valid, 1);
    chk("pre_arst_a_data", a_data, 16'h5555);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_valid", a_valid, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_a_level", a_level, 0);
    chk("arst_b_level", b_level, 0);
    chk("arst_in_ready", in_ready, 1);
    drive(1'b0, 1'b0, 16'h0000);
    #3 rst = 1'b0;
    tick();
    tick();
    chk("ghost_a_valid", a_valid, 0);
    chk("ghost_b_valid", b_valid, 0);

    // Steering with both consumers ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h1234);
    tick();
    chk("steer_a_valid", a_valid, 1);
    chk("steer_a_data", a_data, 16'h1234);
    chk("steer_b_valid0", b_valid, 0);
    drive(1'b1, 1'b1, 16'hABCD);
    tick();
    chk("steer_a_gone", a_valid, 0);
    chk("steer_b_valid", b_valid, 1);
    chk("steer_b_data", b_data, 16'hABCD);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("steer_b_gone", b_valid, 0);
    chk("steer_a_idle", a_valid, 0);

    // Fill A and apply backpressure
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0001);
    tick();
    drive(1'b1, 1'b0, 16'h0002);
    tick();
    chk("fill_a_level", a_level, 2);
    chk("fill_a_head", a_data, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000);
    #1;
    chk("full_ready_selA", in_ready, 0);
    in_sel = 1'b1;
    #1;
    chk("full_ready_selB", in_ready, 1);
    drive(1'b1, 1'b1, 16'h0077);   // B accepts while A is full
    tick();
    chk("other_b_level", b_level, 1);
    chk("other_b_data", b_data, 16'h0077);
    chk("other_a_level", a_level, 2);
    chk("other_a_hold", a_data, 16'h0001);
    drive(1'b1, 1'b0, 16'h0003);   // rejected: A full at the edge, pop too
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    chk("rej_a_level", a_level, 1);
    chk("rej_a_data", a_data, 16'h0002);
    chk("rej_b_level", b_level, 0);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("drain_a_level", a_level, 0);
    chk("drain_a_data", a_data, 16'h0000);

    // Alternate push/pop on B across pointer wrap
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 16'h0010 + 16'(i));
      tick();
      chk("wrap_b_valid", b_valid, 1);
      chk("wrap_b_data", b_data, 16'h0010 + 16'(i));
      chk("wrap_b_level", b_level, 1);
      chk("wrap_a_valid", a_valid, 0);
      drive(1'b0, 1'b0, 16'h0000);
      tick();
      chk("wrap_b_empty", b_level, 0);
    end

    // Pop requests on empty A
    a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_a_level", a_level, 0);
      chk("empty_a_valid", a_valid, 0);
    end
    drive(1'b1, 1'b0, 16'h00FF);   // push and ignored pop on empty queue
    tick();
    chk("empty_push_valid", a_valid, 1);
    chk("empty_push_data", a_data, 16'h00FF);
    chk("empty_push_level", a_level, 1);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("empty_push_drain", a_level, 0);

    // Simultaneous push and pop on a non-empty queue
    a_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0050);
    tick();
    a_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0051);
    tick();
    chk("pushpop_level", a_level, 1);
    chk("pushpop_data", a_data, 16'h0051);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("pushpop_drain", a_level, 0);

    // Reset mid-operation discards buffered words
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0001);
    tick();
    drive(1'b1, 1'b0, 16'h0002);
    tick();
    drive(1'b1, 1'b1, 16'h0003);
    tick();
    drive(1'b0, 1'b0, 16'h0000);
    chk("mid_a_level", a_level, 2);
    chk("mid_b_level", b_level, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_a_data", a_data, 0);
    chk("mid_rst_b_data", b_data, 0);
    chk("mid_rst_a_level", a_level, 0);
    #2 rst = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h0004);
    tick();
    chk("post_b_valid", b_valid, 1);
    chk("post_b_data", b_data, 16'h0004);
    chk("post_a_valid", a_valid, 0);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("post_b_gone", b_valid, 0);
    chk("post_a_none", a_valid, 0);
    tick();
    chk("post_b_none", b_valid, 0);
    chk("post_a_none2", a_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux_1x2_buf.md
Name: demux_1x2_buf

Overview:
- 16-bit 1-to-2 demultiplexer with buffering. It takes one producer stream and steers each word, selected by `in_sel`, into one of two output channels.
- Each output channel has its own small FIFO and a valid/ready handshake.
- Used on the datapath wherever one result bus must feed two independent consumers that stall separately (e.g. writeback vs. store path).

Parameters:
- `WIDTH`, 16, data width of input and both outputs.
- `DEPTH`, 2, entries per output FIFO; power of two, minimum 2.
- `LW`, `$clog2(DEPTH)+1`, width of the level outputs (derived, not overridden).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  the selected channel can accept a word this cycle.
- `in_sel`  input  1  0 steers to channel A, 1 steers to channel B.
- `in_data`  input  WIDTH  input word.
- `a_valid`  output  1  channel A FIFO is non-empty.
- `a_ready`  input  1  consumer A takes the head word.
- `a_data`  output  WIDTH  channel A head word.
- `a_level`  output  LW  channel A occupancy.
- `b_valid`  output  1  channel B FIFO is non-empty.
- `b_ready`  input  1  consumer B takes the head word.
- `b_data`  output  WIDTH  channel B head word.
- `b_level`  output  LW  channel B occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - Read/write pointers and levels of both FIFOs are cleared.
  - `a_valid`, `b_valid` = 0; `a_level`, `b_level` = 0; `a_data`, `b_data` = 0.
  - `in_ready` = 1 after reset, since both FIFOs are empty.
  - Storage array contents are not reset.
  - Asserting `rst` mid-operation discards all buffered words at once; nothing is delivered afterwards.
- Input handshake:
  - `in_ready` is combinational: `(in_sel==0) ? !a_full : !b_full`.
  - A push occurs on a rising edge when `in_valid && in_ready`. The word is written to the FIFO chosen by `in_sel` only; the other FIFO is untouched.
  - `in_ready` may depend on `in_sel` but never on `in_valid`.
- Output handshake, per channel X in {a, b}:
  - `X_valid = (X_level != 0)`.
  - `X_data` = the head entry when `X_valid` is high, and 0 when empty.
  - A pop occurs on a rising edge when `X_valid && X_ready`.
  - `X_data` and `X_valid` hold stable while `X_valid && !X_ready`.
- Latency: a word pushed at edge k is visible on `X_valid`/`X_data` after edge k. There is no combinational input-to-output bypass, so minimum latency is 1 cycle.
- Ordering: strict FIFO order within each channel; no ordering between channels.
- Full: `X_level == DEPTH`.
  - A full FIFO blocks a push even if it pops in the same cycle; `in_ready` is computed from the pre-edge level.
  - A full channel does not stall the other channel; a push with `in_sel` selecting the non-full channel proceeds.
- Empty:
  - A pop request on an empty channel (`X_ready` while `X_valid` = 0) is ignored.
  - Level stays 0; it never underflows.
- Simultaneous push and pop on the same non-full, non-empty channel: level unchanged, head advances, new word is appended at the tail.
- Simultaneous push and pop on an empty channel: the pop is ignored, the push succeeds, and level becomes 1.
- Level update: `X_level_next = X_level + push_X - pop_X`.
- Pointer wrap: read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- `in_sel` and `in_data` are don't-care when `in_valid` = 0.

Test Plan:
- Reset check: assert `rst` asynchronously (between edges) with `in_valid` = 1 → immediately `a_valid` = `b_valid` = 0, levels 0, `in_ready` = 1; after release, no ghost words appear on either channel.
- Steering: push 16'h1234 (`in_sel` = 0) then 16'hABCD (`in_sel` = 1), with `a_ready` = `b_ready` = 1 → `a_data` = 1234 for one cycle and `b_data` = ABCD for one cycle, each 1 cycle after its push; the other channel is never valid.
- Fill and backpressure on A (`DEPTH` = 2, `a_ready` = 0): push 0001, 0002 → `a_level` = 2, `in_ready` = 0 while `in_sel` = 0, and `in_ready` = 1 with `in_sel` = 1. Attempt a push of 0003 to A with `a_ready` = 1 in the same cycle → 0003 is rejected; 0001 is popped and `a_level` = 1.
- Wrap-around: alternate push/pop on B for 5 words 0010..0014 with `b_ready` = 1 → outputs appear in order 0010..0014, `b_level` ≤ 1 throughout, and pointers wrap cleanly.
- Pop on empty: `a_ready` = 1 with A empty for 3 cycles, then push 00FF to A → `a_level` never goes negative; 00FF appears 1 cycle after the push.
- Mid-operation reset: A holds 0001, 0002 and B holds 0003; pulse `rst` → both channels are empty and `a_data` = `b_data` = 0; a subsequent push of 0004 to B is the only word delivered.
